// File: rtl/stall_sched.sv
// -----------------------------------------------------------------------------
// stall_sched
//   Central stall scheduler for the 5-stage MIPS pipeline.
//
//   It merges three stall causes into a single thermometer-coded stall bus:
//     * the ID load-use interlock,
//     * divider occupancy in EX,
//     * data-SRAM wait in MEM.
//   It also sequences the multi-cycle divider, with a watchdog and a flush
//   abort, and keeps saturating per-cause stall counters.
//
// Ports
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   stallreq_id  load-use hazard detected in ID
//   div_start    div/divu in EX is issuing to the divider
//   div_ready    divider result valid (held until consumed)
//   mem_wait     data SRAM not ready for the MEM access
//   flush        pipeline flush (exception/eret)
//   perf_clr     synchronous clear of the counters and the sticky timeout flag
//   stall[5:0]   stop mask; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
//   div_busy     divider operation in flight
//   div_cancel   one-cycle abort pulse to the divider
//   div_timeout  sticky watchdog error
//   cnt_id/cnt_div/cnt_mem  stall-cycle counters per cause
// -----------------------------------------------------------------------------
module stall_sched #(
   parameter int DIV_MAX_CYCLES = 40,
   parameter int DIV_CNT_W      = 6,
   parameter int PERF_W         = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              stallreq_id,
   input  logic              div_start,
   input  logic              div_ready,
   input  logic              mem_wait,
   input  logic              flush,
   input  logic              perf_clr,
   output logic [5:0]        stall,
   output logic              div_busy,
   output logic              div_cancel,
   output logic              div_timeout,
   output logic [PERF_W-1:0] cnt_id,
   output logic [PERF_W-1:0] cnt_div,
   output logic [PERF_W-1:0] cnt_mem
);

   typedef enum logic {
      IDLE     = 1'b0,
      DIV_WAIT = 1'b1
   } state_t;

   localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_MAX_CYCLES - 1);

   state_t               state, state_nxt;
   logic [DIV_CNT_W-1:0] div_cnt, div_cnt_nxt;
   logic                 in_wait;
   logic                 timeout_hit;
   logic                 s_id, s_div, s_mem;
   logic                 cancel_nxt;
   logic                 cancel_p1;
   logic                 cnt_en;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Deepest active cause wins; the result is always a run of ones from bit0.
   function automatic logic [5:0] stall_mask(input logic id, input logic dv,
                                             input logic mem);
      if (mem)     return 6'b011111;
      else if (dv) return 6'b001111;
      else if (id) return 6'b000111;
      else         return 6'b000000;
   endfunction

   // ---- stage 0: combinational cause decode and next state ----
   assign in_wait     = (state == DIV_WAIT);
   // The watchdog never fires while a result is pending (div_ready=1).
   assign timeout_hit = in_wait && (div_cnt == DIV_LAST) && !div_ready;

   assign s_id  = stallreq_id;
   assign s_div = ((state == IDLE) && div_start) ||
                  (in_wait && !div_ready && !timeout_hit);
   assign s_mem = mem_wait;

   // stall is combinational, so it is masked explicitly while reset is held.
   assign stall    = (!resetn || flush) ? 6'b000000 : stall_mask(s_id, s_div, s_mem);
   assign div_busy = in_wait;

   assign cancel_nxt = (flush && in_wait) || timeout_hit;
   assign cnt_en     = !flush;

   always_comb begin
      state_nxt   = state;
      div_cnt_nxt = div_cnt;
      case (state)
         IDLE: begin
            if (div_start && !flush) begin
               state_nxt   = DIV_WAIT;
               div_cnt_nxt = '0;
            end
         end
         DIV_WAIT: begin
            if (flush) begin
               state_nxt = IDLE;
            end else if (div_ready && !mem_wait) begin
               // EX consumes the result this cycle.
               state_nxt = IDLE;
            end else if (timeout_hit) begin
               state_nxt = IDLE;
            end else if (!div_ready) begin
               // With div_ready held behind mem_wait the count is frozen.
               div_cnt_nxt = div_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- stage 1: registered control, flags and counters ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         div_cnt     <= '0;
         cancel_p1   <= 1'b0;
         div_timeout <= 1'b0;
         cnt_id      <= '0;
         cnt_div     <= '0;
         cnt_mem     <= '0;
      end else begin
         state     <= state_nxt;
         div_cnt   <= div_cnt_nxt;
         cancel_p1 <= cancel_nxt;
         if (perf_clr) begin
            div_timeout <= 1'b0;
            cnt_id      <= '0;
            cnt_div     <= '0;
            cnt_mem     <= '0;
         end else begin
            if (timeout_hit)     div_timeout <= 1'b1;
            if (cnt_en && s_id)  cnt_id      <= sat_inc(cnt_id);
            if (cnt_en && s_div) cnt_div     <= sat_inc(cnt_div);
            if (cnt_en && s_mem) cnt_mem     <= sat_inc(cnt_mem);
         end
      end
   end

   assign div_cancel = cancel_p1;

endmodule

// File: tb/tb_stall_sched.sv
module tb_stall_sched;

   typedef enum int {F_STALL, F_BUSY, F_CANCEL, F_TMO, F_CID, F_CDIV, F_CMEM, F_CMEM4} fld_e;

   typedef struct {
      string       nm;
      fld_e        f;
      logic [31:0] v;
   } sb_e;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        stallreq_id = 1'b0;
   logic        div_start = 1'b0;
   logic        div_ready = 1'b0;
   logic        mem_wait = 1'b0;
   logic        flush = 1'b0;
   logic        perf_clr = 1'b0;

   logic [5:0]  stall;
   logic        div_busy, div_cancel, div_timeout;
   logic [31:0] cnt_id, cnt_div, cnt_mem;

   logic [5:0]  s_stall;
   logic        s_busy, s_cancel, s_tmo;
   logic [3:0]  s_cid, s_cdiv, s_cmem;

   sb_e         sb[$];
   sb_e         mon_e;
   logic [31:0] mon_a;
   int          n_total = 0;
   int          n_pass  = 0;

   stall_sched #(.DIV_MAX_CYCLES(40), .DIV_CNT_W(6), .PERF_W(32)) u_dut (
      .clk(clk), .resetn(resetn), .stallreq_id(stallreq_id), .div_start(div_start),
      .div_ready(div_ready), .mem_wait(mem_wait), .flush(flush), .perf_clr(perf_clr),
      .stall(stall), .div_busy(div_busy), .div_cancel(div_cancel),
      .div_timeout(div_timeout), .cnt_id(cnt_id), .cnt_div(cnt_div), .cnt_mem(cnt_mem)
   );

   // Narrow-counter instance sharing the same stimulus, for saturation.
   stall_sched #(.DIV_MAX_CYCLES(40), .DIV_CNT_W(6), .PERF_W(4)) u_sat (
      .clk(clk), .resetn(resetn), .stallreq_id(stallreq_id), .div_start(div_start),
      .div_ready(div_ready), .mem_wait(mem_wait), .flush(flush), .perf_clr(perf_clr),
      .stall(s_stall), .div_busy(s_busy), .div_cancel(s_cancel),
      .div_timeout(s_tmo), .cnt_id(s_cid), .cnt_div(s_cdiv), .cnt_mem(s_cmem)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] act(input fld_e f);
      case (f)
         F_STALL:  return {26'b0, stall};
         F_BUSY:   return {31'b0, div_busy};
         F_CANCEL: return {31'b0, div_cancel};
         F_TMO:    return {31'b0, div_timeout};
         F_CID:    return cnt_id;
         F_CDIV:   return cnt_div;
         F_CMEM:   return cnt_mem;
         F_CMEM4:  return {28'b0, s_cmem};
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: every expectation queued for this cycle is checked mid-cycle.
   always @(negedge clk) begin
      while (sb.size() != 0) begin
         mon_e = sb.pop_front();
         mon_a = act(mon_e.f);
         n_total++;
         if (mon_a === mon_e.v) n_pass++;
         else $display("FAIL %s: got %0h expected %0h (t=%0t)", mon_e.nm, mon_a, mon_e.v, $time);
      end
   end

   task automatic cyc(input bit rn, input bit id, input bit ds, input bit dr,
                      input bit mw, input bit fl, input bit pc);
      @(posedge clk);
      #1;
      resetn = rn; stallreq_id = id; div_start = ds; div_ready = dr;
      mem_wait = mw; flush = fl; perf_clr = pc;
   endtask

   task automatic chk(input string nm, input fld_e f, input logic [31:0] v);
      sb_e e;
      e.nm = nm; e.f = f; e.v = v;
      sb.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset, with a load-use request that must be masked.
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("rst_stall", F_STALL, 32'h00); chk("rst_busy", F_BUSY, 0);
      chk("rst_cancel", F_CANCEL, 0);    chk("rst_tmo", F_TMO, 0);
      chk("rst_cid", F_CID, 0); chk("rst_cdiv", F_CDIV, 0); chk("rst_cmem", F_CMEM, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("idle_stall", F_STALL, 32'h00); chk("idle_cid", F_CID, 0);

      // Load-use, one cycle.
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("lu_stall", F_STALL, 32'h07);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("lu_stall_after", F_STALL, 32'h00); chk("lu_cid", F_CID, 1);

      // Divide: start at cycle 0, ready at cycle 33.
      cyc(1, 0, 1, 0, 0, 0, 0);
      chk("div_c0_stall", F_STALL, 32'h0F); chk("div_c0_busy", F_BUSY, 0);
      for (int k = 1; k <= 32; k++) begin
         cyc(1, 0, 0, 0, 0, 0, 0);
         chk("div_wait_stall", F_STALL, 32'h0F); chk("div_wait_busy", F_BUSY, 1);
         if (k == 1) chk("div_c1_cdiv", F_CDIV, 1);
      end
      cyc(1, 0, 0, 1, 0, 0, 0);
      chk("div_c33_stall", F_STALL, 32'h00); chk("div_c33_busy", F_BUSY, 1);
      chk("div_c33_cdiv", F_CDIV, 33);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("div_c34_busy", F_BUSY, 0); chk("div_c34_cdiv", F_CDIV, 33);
      chk("div_c34_cancel", F_CANCEL, 0); chk("div_c34_cid", F_CID, 1);

      // Overlap: ready held behind mem_wait for 3 cycles.
      cyc(1, 0, 1, 0, 0, 0, 0);
      chk("ov_start_stall", F_STALL, 32'h0F);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("ov_wait_stall", F_STALL, 32'h0F);
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 0, 1, 1, 0, 0);
         chk("ov_mem_stall", F_STALL, 32'h1F); chk("ov_mem_busy", F_BUSY, 1);
      end
      cyc(1, 0, 0, 1, 0, 0, 0);
      chk("ov_exit_stall", F_STALL, 32'h00); chk("ov_exit_busy", F_BUSY, 1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("ov_idle_busy", F_BUSY, 0); chk("ov_cdiv", F_CDIV, 35);
      chk("ov_cmem", F_CMEM, 3); chk("ov_cmem4", F_CMEM4, 3);

      // Timeout: never ready.
      cyc(1, 0, 1, 0, 0, 0, 0);
      chk("to_start_stall", F_STALL, 32'h0F);
      for (int k = 1; k <= 39; k++) begin
         cyc(1, 0, 0, 0, 0, 0, 0);
         chk("to_wait_stall", F_STALL, 32'h0F); chk("to_wait_cancel", F_CANCEL, 0);
      end
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("to_c40_stall", F_STALL, 32'h00); chk("to_c40_busy", F_BUSY, 1);
      chk("to_c40_cancel", F_CANCEL, 0); chk("to_c40_tmo", F_TMO, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("to_c41_busy", F_BUSY, 0); chk("to_c41_cancel", F_CANCEL, 1);
      chk("to_c41_tmo", F_TMO, 1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("to_c42_cancel", F_CANCEL, 0); chk("to_c42_tmo", F_TMO, 1);
      chk("to_c42_cdiv", F_CDIV, 75);
      cyc(1, 0, 0, 0, 0, 0, 1);
      chk("clr_tmo_before", F_TMO, 1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("clr_tmo", F_TMO, 0); chk("clr_cid", F_CID, 0);
      chk("clr_cdiv", F_CDIV, 0); chk("clr_cmem", F_CMEM, 0);

      // Flush at DIV_WAIT cycle 5, with a simultaneous div_start and load-use.
      cyc(1, 0, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(1, 0, 0, 0, 0, 0, 0);
         chk("fl_wait_stall", F_STALL, 32'h0F);
      end
      cyc(1, 1, 1, 0, 0, 1, 0);
      chk("fl_c5_stall", F_STALL, 32'h00); chk("fl_c5_busy", F_BUSY, 1);
      chk("fl_c5_cancel", F_CANCEL, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("fl_c6_busy", F_BUSY, 0); chk("fl_c6_cancel", F_CANCEL, 1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("fl_c7_cancel", F_CANCEL, 0); chk("fl_cdiv", F_CDIV, 5);
      chk("fl_cid", F_CID, 0);
      // Flush while IDLE blocks div_start acceptance; no cancel.
      cyc(1, 0, 1, 0, 0, 1, 0);
      chk("fli_stall", F_STALL, 32'h00);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("fli_busy", F_BUSY, 0); chk("fli_cancel", F_CANCEL, 0);
      chk("fli_cdiv", F_CDIV, 5);

      // Saturation: 20 cycles of mem_wait.
      for (int k = 0; k < 20; k++) begin
         cyc(1, 0, 0, 0, 1, 0, 0);
         chk("sat_stall", F_STALL, 32'h1F);
      end
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("sat_cmem32", F_CMEM, 20); chk("sat_cmem4", F_CMEM4, 32'hF);

      // Async reset in the middle of a divide.
      cyc(1, 0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("ar_pre_busy", F_BUSY, 1);
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("ar_stall", F_STALL, 32'h00); chk("ar_busy", F_BUSY, 0);
      chk("ar_cancel", F_CANCEL, 0); chk("ar_tmo", F_TMO, 0);
      chk("ar_cid", F_CID, 0); chk("ar_cdiv", F_CDIV, 0); chk("ar_cmem", F_CMEM, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("ar_hold_cancel", F_CANCEL, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("ar_rel_busy", F_BUSY, 0); chk("ar_rel_cancel", F_CANCEL, 0);

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/stall_sched.md
Name: stall_sched

Overview:
- Central pipeline stall scheduler for the 5-stage MIPS core.
- Merges three stall causes into the 6-bit stall bus consumed by the IF/ID/EX/MEM/WB pipeline registers:
  - ID load-use interlock.
  - Multi-cycle divider occupancy in EX.
  - Data-SRAM wait in MEM.
- Sequences the divider: tracks the in-flight operation, aborts it on flush or timeout, and keeps per-cause stall performance counters.

Parameters:
- DIV_MAX_CYCLES, 40, cycles in DIV_WAIT before the watchdog aborts the divide. Must be < 2^DIV_CNT_W.
- DIV_CNT_W, 6, width of the divide cycle counter.
- PERF_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- stallreq_id  in  1  load-use hazard detected in ID this cycle
- div_start  in  1  div/divu in EX issuing to divider this cycle
- div_ready  in  1  divider result valid; held by divider until consumed
- mem_wait  in  1  data SRAM not ready for the MEM-stage access
- flush  in  1  pipeline flush (exception/eret)
- perf_clr  in  1  synchronous clear of counters and sticky flag
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop
- div_busy  out  1  state == DIV_WAIT
- div_cancel  out  1  one-cycle pulse: abort divider
- div_timeout  out  1  sticky watchdog error
- cnt_id  out  PERF_W  cycles with load-use stall
- cnt_div  out  PERF_W  cycles with divider stall
- cnt_mem  out  PERF_W  cycles with memory stall

Behaviour:
- Reset (resetn=0, async): state=IDLE, div counter=0, div_cancel=0, div_timeout=0, all cnt_*=0.
  - stall=6'b000000 while in reset.
- States:
  - IDLE:
    - div_start & ~flush -> DIV_WAIT.
  - DIV_WAIT:
    - flush -> IDLE.
    - div_ready & ~mem_wait -> IDLE (EX consumes the result this cycle).
    - counter == DIV_MAX_CYCLES-1 & ~div_ready -> IDLE.
    - Otherwise stay; counter +1.
  - Counter cleared on every entry to DIV_WAIT.
- Cause terms (combinational, same cycle):
  - s_id = stallreq_id.
  - s_div = (IDLE & div_start) | (DIV_WAIT & ~div_ready & ~timeout_hit), where timeout_hit = DIV_WAIT & counter == DIV_MAX_CYCLES-1 & ~div_ready.
  - s_mem = mem_wait.
- stall pattern:
  - Deepest active cause wins: s_mem -> 6'b011111; else s_div -> 6'b001111; else s_id -> 6'b000111; else 6'b000000.
  - Always a contiguous run of ones from bit0, so the first non-stopped stage receives a bubble.
- flush:
  - Forces stall = 6'b000000 and suppresses div_start acceptance.
- div_cancel:
  - Registered pulse, high for exactly the one cycle after (flush & DIV_WAIT) or timeout_hit.
  - Never high for two consecutive cycles from a single event.
- div_timeout:
  - Set the cycle after timeout_hit.
  - Cleared only by perf_clr or reset.
- DIV_WAIT with div_ready & mem_wait:
  - Remains in DIV_WAIT.
  - stall = 6'b011111.
  - Counter frozen; it never times out while div_ready=1.
- Counters:
  - Each cnt_x increments by 1 on every cycle its cause term is 1, counted independently (overlapping causes count in every counter).
  - Counting is gated off during flush.
  - Saturate at all-ones; no wrap.
  - perf_clr has priority over increment: value 0 on the next edge.
- Reset asserted mid-divide:
  - Immediate return to IDLE.
  - No div_cancel pulse is generated; the divider is reset by the same resetn.
- div_start while in DIV_WAIT: ignored (EX is already stalled).

Test Plan:
- Load-use: stallreq_id=1 for 1 cycle -> stall=6'b000111 that cycle, 0 after; cnt_id=1.
- Divide: div_start=1 at cycle 0 and div_ready=1 at cycle 33:
  - stall=6'b001111 on cycles 0..32, 0 at cycle 33.
  - State returns to IDLE at cycle 34.
  - cnt_div=33.
- Overlap: mem_wait=1 while in DIV_WAIT with div_ready=1 for 3 cycles:
  - stall=6'b011111 for those 3 cycles; div_busy stays 1.
  - Exit to IDLE on the first cycle with mem_wait=0.
- Timeout: div_start and never div_ready, DIV_MAX_CYCLES=40:
  - Stall released at the 40th DIV_WAIT cycle.
  - div_cancel is a single pulse on the next cycle; div_timeout=1 and sticky.
  - perf_clr clears it.
- Flush mid-divide at DIV_WAIT cycle 5:
  - stall=0 that cycle.
  - div_cancel pulse on the next cycle; IDLE.
  - A simultaneous div_start does not re-enter DIV_WAIT.
- Saturation/reset: preload cnt_mem near max with PERF_W=4 by holding mem_wait 20 cycles:
  - cnt_mem=4'hF, no wrap.
  - resetn low mid-DIV_WAIT -> all outputs 0 asynchronously.
